regfile_sequencer: RTL and testbench

Initiator-side control block for the CPU register file. Accepts one 32-bit instruction at a time and splits it into opcode, register indices and immediate. It then drives the register file's read strobe and hands the operands off to the execute stage. When a result returns, it issues the write-back strobe. It sits between the instruction fetch/decode path and the register file plus ALU, and guarantees that read and write strobes are never asserted together.

---
 rtl/cpu_pkg.sv | 46 ++++
 rtl/instr_field_decode.sv | 22 ++
 rtl/regfile_sequencer.sv | 130 +++++++++++++
 tb/tb_regfile_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, instruction field positions,
// the sequencer state encoding and the write-back classification helper.
package cpu_pkg;

    // Opcodes that matter to the register-file sequencer
    localparam logic [5:0] OP_BEQ = 6'b011110;
    localparam logic [5:0] OP_BLT = 6'b011111;
    localparam logic [5:0] OP_SW  = 6'b011001;
    localparam logic [5:0] OP_SB  = 6'b011011;
    localparam logic [5:0] OP_LDI = 6'b010000;
    localparam logic [5:0] OP_LUI = 6'b010001;
    localparam logic [5:0] OP_LB  = 6'b011010;

    // Instruction word field positions
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int R1_HI  = 25;
    localparam int R1_LO  = 21;
    localparam int R2_HI  = 20;
    localparam int R2_LO  = 16;
    localparam int R3_HI  = 15;
    localparam int R3_LO  = 11;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        EXEC  = 3'd2,
        WAIT  = 3'd3,
        WRITE = 3'd4
    } state_e;

    // Branches and stores produce no register result; everything else does.
    // Partial-field loads still write back: the register file merges the field.
    function automatic logic op_writes_back(input logic [5:0] op);
        logic wb;
        case (op)
            OP_BEQ, OP_BLT, OP_SW, OP_SB: wb = 1'b0;
            OP_LDI, OP_LUI, OP_LB:        wb = 1'b1;
            default:                      wb = 1'b1;
        endcase
        return wb;
    endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Purely combinational split of an instruction word into its fields,
// the sign-extended immediate and the write-back classification.
module instr_field_decode
    import cpu_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [5:0]  opcode_o,
    output logic [4:0]  reg1_o,
    output logic [4:0]  reg2_o,
    output logic [4:0]  reg3_o,
    output logic [31:0] imm_o,
    output logic        writes_back_o
);

    assign opcode_o      = instr_i[OPC_HI:OPC_LO];
    assign reg1_o        = instr_i[R1_HI:R1_LO];
    assign reg2_o        = instr_i[R2_HI:R2_LO];
    assign reg3_o        = instr_i[R3_HI:R3_LO];
    assign imm_o         = {{16{instr_i[IMM_HI]}}, instr_i[IMM_HI:IMM_LO]};
    assign writes_back_o = op_writes_back(instr_i[OPC_HI:OPC_LO]);

endmodule

// File: rtl/regfile_sequencer.sv
// Register-file sequencer: accepts one instruction at a time, strobes the
// register-file read, launches execute, waits for the result and strobes
// the write-back. Strobes are decoded from distinct states so read and
// write can never be asserted together.
module regfile_sequencer
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        exec_done,
    input  logic [31:0] exec_result,
    output logic        exec_start,
    output logic        busy,
    output logic        reg_read,
    output logic        reg_write,
    output logic        reg_reset,
    output logic [5:0]  opcode,
    output logic [4:0]  reg1,
    output logic [4:0]  reg2,
    output logic [4:0]  reg3,
    output logic [31:0] imm,
    output logic [31:0] write_data
);

    state_e      state_q, state_d;
    logic        reg_reset_q;
    logic [5:0]  opcode_q, opcode_d;
    logic [4:0]  reg1_q, reg1_d;
    logic [4:0]  reg2_q, reg2_d;
    logic [4:0]  reg3_q, reg3_d;
    logic [31:0] imm_q, imm_d;
    logic        wb_q, wb_d;
    logic [31:0] write_data_q, write_data_d;

    logic [5:0]  dec_opcode;
    logic [4:0]  dec_reg1, dec_reg2, dec_reg3;
    logic [31:0] dec_imm;
    logic        dec_wb;
    logic        accept;

    instr_field_decode u_decode (
        .instr_i       (instr),
        .opcode_o      (dec_opcode),
        .reg1_o        (dec_reg1),
        .reg2_o        (dec_reg2),
        .reg3_o        (dec_reg3),
        .imm_o         (dec_imm),
        .writes_back_o (dec_wb)
    );

    // Acceptance is only possible in IDLE once the register file is out of reset
    assign instr_ready = (state_q == IDLE) && !reg_reset_q;
    assign accept      = instr_valid && instr_ready;

    // Next-state and capture logic for the instruction sequence
    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        reg1_d       = reg1_q;
        reg2_d       = reg2_q;
        reg3_d       = reg3_q;
        imm_d        = imm_q;
        wb_d         = wb_q;
        write_data_d = write_data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    opcode_d = dec_opcode;
                    reg1_d   = dec_reg1;
                    reg2_d   = dec_reg2;
                    reg3_d   = dec_reg3;
                    imm_d    = dec_imm;
                    wb_d     = dec_wb;
                    state_d  = READ;
                end
            end
            READ:  state_d = EXEC;
            EXEC:  state_d = WAIT;
            WAIT: begin
                if (exec_done) begin
                    write_data_d = exec_result;
                    state_d      = wb_q ? WRITE : IDLE;
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and captured-field registers; reset discards any in-flight instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            reg_reset_q  <= 1'b1;
            opcode_q     <= '0;
            reg1_q       <= '0;
            reg2_q       <= '0;
            reg3_q       <= '0;
            imm_q        <= '0;
            wb_q         <= 1'b0;
            write_data_q <= '0;
        end else begin
            state_q      <= state_d;
            reg_reset_q  <= 1'b0;
            opcode_q     <= opcode_d;
            reg1_q       <= reg1_d;
            reg2_q       <= reg2_d;
            reg3_q       <= reg3_d;
            imm_q        <= imm_d;
            wb_q         <= wb_d;
            write_data_q <= write_data_d;
        end
    end

    assign reg_read   = (state_q == READ);
    assign exec_start = (state_q == EXEC);
    assign reg_write  = (state_q == WRITE);
    assign busy       = (state_q != IDLE);
    assign reg_reset  = reg_reset_q;
    assign opcode     = opcode_q;
    assign reg1       = reg1_q;
    assign reg2       = reg2_q;
    assign reg3       = reg3_q;
    assign imm        = imm_q;
    assign write_data = write_data_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Self-checking bench for regfile_sequencer: directed scenarios followed by
// a random instruction stream, checked against a field/timing reference model.
module tb_regfile_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        exec_done;
    logic [31:0] exec_result;
    logic        exec_start;
    logic        busy;
    logic        reg_read;
    logic        reg_write;
    logic        reg_reset;
    logic [5:0]  opcode;
    logic [4:0]  reg1, reg2, reg3;
    logic [31:0] imm;
    logic [31:0] write_data;

    int n_cmp = 0;
    int n_err = 0;
    int es_cnt = 0;
    int wr_cnt = 0;
    int overlap = 0;
    int accepted = 0;
    logic [5:0] no_wb_ops [4];

    always #5 clk = ~clk;

    regfile_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .exec_done   (exec_done),
        .exec_result (exec_result),
        .exec_start  (exec_start),
        .busy        (busy),
        .reg_read    (reg_read),
        .reg_write   (reg_write),
        .reg_reset   (reg_reset),
        .opcode      (opcode),
        .reg1        (reg1),
        .reg2        (reg2),
        .reg3        (reg3),
        .imm         (imm),
        .write_data  (write_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        if (reg_read && reg_write) overlap++;
        if (exec_start) es_cnt++;
        if (reg_write) wr_cnt++;
    endtask

    // Reference model: fields by plain arithmetic on the instruction word
    function automatic logic [31:0] m_opcode(input logic [31:0] w);
        return w / 32'd67108864;
    endfunction
    function automatic logic [31:0] m_field5(input logic [31:0] w, input int lsb);
        return (w >> lsb) % 32'd32;
    endfunction
    function automatic logic [31:0] m_imm(input logic [31:0] w);
        logic [31:0] lo;
        lo = w % 32'd65536;
        return (lo >= 32'd32768) ? (lo + 32'hFFFF_0000) : lo;
    endfunction
    function automatic bit m_wb(input logic [31:0] w);
        for (int i = 0; i < 4; i++)
            if (m_opcode(w) == {26'd0, no_wb_ops[i]}) return 1'b0;
        return 1'b1;
    endfunction

    // One complete transaction with timing and field checks
    task automatic run_instr(input logic [31:0] iw, input logic [31:0] res,
                             input int delay, input bit spurious, input bit hold_valid);
        int k;
        k = 0;
        while (!instr_ready && k < 20) begin
            tick();
            k++;
        end
        chk("ready_before_accept", instr_ready, 1);
        instr = iw;
        instr_valid = 1'b1;
        accepted++;
        tick();
        if (!hold_valid) instr_valid = 1'b0;
        chk("read_strobe", reg_read, 1);
        chk("no_start_in_read", exec_start, 0);
        chk("ready_low_busy", instr_ready, 0);
        chk("busy_in_read", busy, 1);
        chk("opcode", opcode, m_opcode(iw));
        chk("reg1", reg1, m_field5(iw, 21));
        chk("reg2", reg2, m_field5(iw, 16));
        chk("reg3", reg3, m_field5(iw, 11));
        chk("imm", imm, m_imm(iw));
        tick();
        chk("exec_start", exec_start, 1);
        chk("read_drop", reg_read, 0);
        exec_done = spurious;
        exec_result = ~res;
        tick();
        exec_done = 1'b0;
        for (int d = 0; d < delay; d++) begin
            chk("wait_busy", busy, 1);
            chk("wait_not_ready", instr_ready, 0);
            chk("wait_no_write", reg_write, 0);
            tick();
        end
        exec_done = 1'b1;
        exec_result = res;
        tick();
        exec_done = 1'b0;
        if (m_wb(iw)) begin
            chk("write_strobe", reg_write, 1);
            chk("write_data", write_data, res);
            chk("not_ready_in_write", instr_ready, 0);
            tick();
            chk("write_drop", reg_write, 0);
        end else begin
            chk("no_write_strobe", reg_write, 0);
            chk("write_data_nowb", write_data, res);
        end
        chk("ready_after", instr_ready, 1);
        instr_valid = 1'b0;
    endtask

    initial begin
        int wr_base;
        int es_base;
        int ov_base;
        logic [31:0] r;
        logic [5:0]  op;

        no_wb_ops[0] = 6'b011110;
        no_wb_ops[1] = 6'b011111;
        no_wb_ops[2] = 6'b011001;
        no_wb_ops[3] = 6'b011011;
        reset = 1'b1;
        instr = 32'h0;
        instr_valid = 1'b0;
        exec_done = 1'b0;
        exec_result = 32'h0;

        // Reset values
        tick();
        tick();
        chk("rst_reg_reset", reg_reset, 1);
        chk("rst_ready", instr_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_read", reg_read, 0);
        chk("rst_write", reg_write, 0);
        chk("rst_start", exec_start, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_imm", imm, 0);
        chk("rst_wdata", write_data, 0);

        // instr_valid offered while reg_reset is still high must not be taken
        reset = 1'b0;
        instr = 32'h0022_1800;
        instr_valid = 1'b1;
        tick();
        chk("post_rst_reg_reset", reg_reset, 0);
        chk("post_rst_no_accept", busy, 0);
        chk("post_rst_ready", instr_ready, 1);
        instr_valid = 1'b0;

        // ADD r1,r2,r3
        run_instr(32'h0022_1800, 32'h0000_00AB, 0, 1'b0, 1'b0);
        // BEQ: no write-back
        wr_base = wr_cnt;
        run_instr(32'h7822_0008, 32'h1234_5678, 0, 1'b0, 1'b0);
        chk("beq_no_write", wr_cnt - wr_base, 0);
        // LDI r5 with negative immediate
        run_instr(32'h40A0_FFFF, 32'hDEAD_BEEF, 1, 1'b0, 1'b0);
        // Delayed exec_done, spurious pulse in EXEC, valid held high
        wr_base = wr_cnt;
        run_instr(32'h0443_2000, 32'hCAFE_0001, 10, 1'b1, 1'b1);
        chk("delayed_one_write", wr_cnt - wr_base, 1);

        // Reset in WAIT coinciding with exec_done
        wr_base = wr_cnt;
        instr = 32'h0022_1800;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        tick();
        chk("rstwait_busy_before", busy, 1);
        reset = 1'b1;
        exec_done = 1'b1;
        exec_result = 32'h5555_AAAA;
        tick();
        exec_done = 1'b0;
        chk("rstwait_read", reg_read, 0);
        chk("rstwait_write", reg_write, 0);
        chk("rstwait_start", exec_start, 0);
        chk("rstwait_reg_reset", reg_reset, 1);
        chk("rstwait_busy", busy, 0);
        chk("rstwait_ready", instr_ready, 0);
        chk("rstwait_wdata", write_data, 0);
        reset = 1'b0;
        tick();
        chk("rstwait_ready_back", instr_ready, 1);
        tick();
        chk("rstwait_no_write", wr_cnt - wr_base, 0);

        // Random stream
        es_base = es_cnt;
        ov_base = overlap;
        accepted = 0;
        for (int n = 0; n < 200; n++) begin
            r = $urandom();
            if ($urandom_range(0, 1) == 1) op = no_wb_ops[$urandom_range(0, 3)];
            else op = 6'($urandom_range(0, 63));
            run_instr({op, r[25:0]}, $urandom(), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), 1'b0);
        end
        chk("stream_exec_starts", es_cnt - es_base, accepted);
        chk("stream_rw_overlap", overlap - ov_base, 0);
        chk("total_rw_overlap", overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
